// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - symbolic RV32I operation handshake between a producer and the loader
//
// Ports:
//   InValid      producer -> loader   operation present
//   InReady      loader   -> producer loader accepts an operation this cycle
//   Op           producer -> loader   operation code (0..13 legal, 14/15 illegal)
//   Rd/Rs1/Rs2   producer -> loader   register fields
//   Imm          producer -> loader   signed immediate as a full value (LUI: final upper value)
//   master modport: producer side; slave modport: loader side.
interface instr_encoder_loader_if;
    logic        InValid;
    logic        InReady;
    logic [3:0]  Op;
    logic [4:0]  Rd;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [31:0] Imm;

    modport master (
        output InValid, Op, Rd, Rs1, Rs2, Imm,
        input  InReady
    );

    modport slave (
        input  InValid, Op, Rd, Rs1, Rs2, Imm,
        output InReady
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes symbolic RV32I operations and streams them into instruction memory
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   Start         one-cycle pulse, opens a load session (from IDLE or DONE)
//   Finish        one-cycle pulse, closes the session once the last write drains
//   op_if         slave side of the operation handshake (InValid/InReady/Op/Rd/Rs1/Rs2/Imm)
//   MemWE         one-cycle write strobe per encoded word
//   MemAddr       byte address of the write (BASE_ADDR, +4, +8, ...)
//   MemWData      encoded 32-bit instruction
//   Busy          session in LOAD or DRAIN
//   Done          session completed (level, cleared by the next Start)
//   Full          Count has reached DEPTH
//   Count         words written this session
//   ErrIllegal    sticky, an operation was rejected this session
module instr_encoder_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      Start,
    input  logic                      Finish,
    instr_encoder_loader_if.slave     op_if,
    output logic                      MemWE,
    output logic [ADDR_W-1:0]         MemAddr,
    output logic [31:0]               MemWData,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Full,
    output logic [$clog2(DEPTH):0]    Count,
    output logic                      ErrIllegal
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BEQ  = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     count;
    logic              err;

    logic              fire;
    logic              legal;
    logic [31:0]       enc;
    logic signed [31:0] simm;
    logic              fits_i;
    logic              fits_b;
    logic              fits_j;
    logic              fits_u;

    assign Full          = (count == DEPTH_C);
    assign op_if.InReady = (state == S_LOAD) && !Full;
    assign Busy          = (state == S_LOAD) || (state == S_DRAIN);
    assign Done          = (state == S_DONE);
    assign Count         = count;
    assign ErrIllegal    = err;
    assign fire          = op_if.InValid && op_if.InReady;

    // Immediate range checks on the full signed value; branch and jump
    // offsets must also be even because bit 0 is not encoded.
    assign simm   = op_if.Imm;
    assign fits_i = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign fits_b = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !op_if.Imm[0];
    assign fits_j = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !op_if.Imm[0];
    assign fits_u = (op_if.Imm[11:0] == 12'd0);

    always_comb begin
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] im;
        rd    = op_if.Rd;
        rs1   = op_if.Rs1;
        rs2   = op_if.Rs2;
        im    = op_if.Imm;
        enc   = 32'd0;
        legal = 1'b0;
        case (op_if.Op)
            4'd0:  begin enc = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R}; legal = 1'b1; end
            4'd1:  begin enc = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R}; legal = 1'b1; end
            4'd2:  begin enc = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R}; legal = 1'b1; end
            4'd3:  begin enc = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R}; legal = 1'b1; end
            4'd4:  begin enc = {7'b0000000, rs2, rs1, 3'b010, rd, OPC_R}; legal = 1'b1; end
            4'd5:  begin enc = {im[11:0], rs1, 3'b000, rd, OPC_I};    legal = fits_i; end
            4'd6:  begin enc = {im[11:0], rs1, 3'b110, rd, OPC_I};    legal = fits_i; end
            4'd7:  begin enc = {im[11:0], rs1, 3'b111, rd, OPC_I};    legal = fits_i; end
            4'd8:  begin enc = {im[11:0], rs1, 3'b010, rd, OPC_LW};   legal = fits_i; end
            4'd9:  begin enc = {im[11:5], rs2, rs1, 3'b010, im[4:0], OPC_SW}; legal = fits_i; end
            4'd10: begin
                enc   = {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], OPC_BEQ};
                legal = fits_b;
            end
            4'd11: begin
                enc   = {im[20], im[10:1], im[11], im[19:12], rd, OPC_JAL};
                legal = fits_j;
            end
            4'd12: begin enc = {im[11:0], rs1, 3'b000, rd, OPC_JALR}; legal = fits_i; end
            4'd13: begin enc = {im[31:12], rd, OPC_LUI};              legal = fits_u; end
            default: begin enc = 32'd0; legal = 1'b0; end
        endcase
    end

    // Count and the address counter advance at acceptance so Full (and hence
    // InReady) already reflects a word whose write is still one cycle away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            addr     <= BASE_ADDR;
            count    <= '0;
            err      <= 1'b0;
            MemWE    <= 1'b0;
            MemAddr  <= BASE_ADDR;
            MemWData <= 32'd0;
        end else begin
            MemWE <= 1'b0;
            if (fire) begin
                if (legal) begin
                    MemWE    <= 1'b1;
                    MemWData <= enc;
                    MemAddr  <= addr;
                    addr     <= addr + ADDR_W'(4);
                    count    <= count + CW'(1);
                end else begin
                    err <= 1'b1;
                end
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state <= S_LOAD;
                        count <= '0;
                        err   <= 1'b0;
                        addr  <= BASE_ADDR;
                    end
                end
                S_LOAD: begin
                    if (Finish) begin
                        state <= S_DRAIN;
                    end
                end
                // Any word accepted alongside Finish is on the write port
                // during this cycle, so one DRAIN cycle always suffices.
                S_DRAIN: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - randomized and directed bench for instr_encoder_loader
module tb_instr_encoder_loader;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic        Finish;
    logic        MemWE;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        Busy;
    logic        Done;
    logic        Full;
    logic [2:0]  Count;
    logic        ErrIllegal;

    instr_encoder_loader_if op_if ();

    instr_encoder_loader #(
        .ADDR_W   (32),
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .Finish    (Finish),
        .op_if     (op_if),
        .MemWE     (MemWE),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .Busy      (Busy),
        .Done      (Done),
        .Full      (Full),
        .Count     (Count),
        .ErrIllegal(ErrIllegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: session phase 0 idle, 1 load, 2 drain, 3 done.
    int          m_phase;
    int          m_count;
    logic [31:0] m_addr;
    logic        m_err;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_maddr;

    function automatic bit ref_legal(input int op, input int imm);
        case (op)
            0, 1, 2, 3, 4:        return 1'b1;
            5, 6, 7, 8, 9, 12:    return (imm >= -2048) && (imm <= 2047);
            10:                   return (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
            11:                   return (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
            13:                   return (imm & 32'hfff) == 0;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1,
                                            input int rs2, input int imm);
        int f3;
        int f7;
        int base_r;
        f7 = (op == 1) ? 32 : 0;
        case (op)
            2, 7:    f3 = 7;
            3, 6:    f3 = 6;
            4, 8, 9: f3 = 2;
            default: f3 = 0;
        endcase
        base_r = (rs1 << 15) | (f3 << 12);
        case (op)
            0, 1, 2, 3, 4: return (f7 << 25) | (rs2 << 20) | base_r | (rd << 7) | 'h33;
            5, 6, 7:       return ((imm & 'hfff) << 20) | base_r | (rd << 7) | 'h13;
            8:             return ((imm & 'hfff) << 20) | base_r | (rd << 7) | 'h03;
            12:            return ((imm & 'hfff) << 20) | base_r | (rd << 7) | 'h67;
            9:             return (((imm >> 5) & 'h7f) << 25) | (rs2 << 20) | base_r
                                  | ((imm & 'h1f) << 7) | 'h23;
            10:            return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3f) << 25)
                                  | (rs2 << 20) | base_r | (((imm >> 1) & 'hf) << 8)
                                  | (((imm >> 11) & 1) << 7) | 'h63;
            11:            return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3ff) << 21)
                                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hff) << 12)
                                  | (rd << 7) | 'h6f;
            13:            return (imm & 32'hfffff000) | (rd << 7) | 'h37;
            default:       return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_count = 0;
        m_addr  = BASE;
        m_err   = 1'b0;
        m_we    = 1'b0;
        m_wdata = 32'd0;
        m_maddr = BASE;
    endtask

    task automatic model_step(input bit st, input bit fin, input bit v, input int op,
                              input int rd, input int rs1, input int rs2, input int imm);
        bit ready;
        ready = (m_phase == 1) && (m_count < DEPTH);
        m_we  = 1'b0;
        if (v && ready) begin
            if (ref_legal(op, imm)) begin
                m_we    = 1'b1;
                m_wdata = ref_enc(op, rd, rs1, rs2, imm);
                m_maddr = m_addr;
                m_addr  = m_addr + 4;
                m_count = m_count + 1;
            end else begin
                m_err = 1'b1;
            end
        end
        if ((m_phase == 0 || m_phase == 3) && st) begin
            m_phase = 1;
            m_count = 0;
            m_err   = 1'b0;
            m_addr  = BASE;
        end else if (m_phase == 1 && fin) begin
            m_phase = 2;
        end else if (m_phase == 2) begin
            m_phase = 3;
        end
    endtask

    task automatic check_all();
        chk("memwe", {31'd0, MemWE}, {31'd0, m_we});
        if (m_we) begin
            chk("memaddr", MemAddr, m_maddr);
            chk("memwdata", MemWData, m_wdata);
        end
        chk("busy", {31'd0, Busy}, {31'd0, (m_phase == 1 || m_phase == 2)});
        chk("done", {31'd0, Done}, {31'd0, (m_phase == 3)});
        chk("full", {31'd0, Full}, {31'd0, (m_count == DEPTH)});
        chk("count", {29'd0, Count}, 32'(m_count));
        chk("errillegal", {31'd0, ErrIllegal}, {31'd0, m_err});
        chk("inready", {31'd0, op_if.InReady}, {31'd0, (m_phase == 1 && m_count < DEPTH)});
    endtask

    task automatic go(input bit st, input bit fin, input bit v, input int op,
                      input int rd, input int rs1, input int rs2, input int imm);
        Start         = st;
        Finish        = fin;
        op_if.InValid = v;
        op_if.Op      = op[3:0];
        op_if.Rd      = rd[4:0];
        op_if.Rs1     = rs1[4:0];
        op_if.Rs2     = rs2[4:0];
        op_if.Imm     = imm;
        @(posedge clk);
        model_step(st, fin, v, op, rd, rs1, rs2, imm);
        #1;
        check_all();
    endtask

    task automatic opx(input int op, input int rd, input int rs1, input int rs2, input int imm);
        go(0, 0, 1, op, rd, rs1, rs2, imm);
    endtask

    task automatic start_s();
        go(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic end_s();
        go(0, 1, 0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_memwe"}, {31'd0, MemWE}, 32'd0);
        chk({tag, "_memaddr"}, MemAddr, BASE);
        chk({tag, "_memwdata"}, MemWData, 32'd0);
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, Done}, 32'd0);
        chk({tag, "_full"}, {31'd0, Full}, 32'd0);
        chk({tag, "_count"}, {29'd0, Count}, 32'd0);
        chk({tag, "_err"}, {31'd0, ErrIllegal}, 32'd0);
        chk({tag, "_inready"}, {31'd0, op_if.InReady}, 32'd0);
    endtask

    function automatic int gen_imm(input int op);
        int v;
        bit bad;
        bad = ($urandom_range(0, 4) == 0);
        case (op)
            5, 6, 7, 8, 9, 12: begin
                v = $urandom_range(0, 4095);
                v = v - 2048;
                if (bad) v = (v < 0) ? v - 2048 : v + 2048;
            end
            10: begin
                v = $urandom_range(0, 4095);
                v = (v - 2048) * 2;
                if (bad) v = v + 1;
            end
            11: begin
                v = $urandom_range(0, 1048575);
                v = (v - 524288) * 2;
                if (bad) v = v + 1;
            end
            13: begin
                v = $urandom & 32'hfffff000;
                if (bad) v = v | $urandom_range(1, 4095);
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        rst_n         = 1'b0;
        Start         = 1'b0;
        Finish        = 1'b0;
        op_if.InValid = 1'b0;
        op_if.Op      = 4'd0;
        op_if.Rd      = 5'd0;
        op_if.Rs1     = 5'd0;
        op_if.Rs2     = 5'd0;
        op_if.Imm     = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADDI x1, x0, 5
        start_s();
        opx(5, 1, 0, 0, 5);
        chk("t1_data", MemWData, 32'h00500093);
        chk("t1_addr", MemAddr, BASE);
        chk("t1_count", {29'd0, Count}, 32'd1);
        end_s();

        // Back-to-back ADD then SUB with InValid held high
        start_s();
        opx(0, 3, 1, 2, 0);
        chk("t2_add", MemWData, 32'h002081B3);
        chk("t2_add_addr", MemAddr, BASE);
        opx(1, 3, 1, 2, 0);
        chk("t2_sub", MemWData, 32'h402081B3);
        chk("t2_sub_addr", MemAddr, BASE + 4);
        end_s();

        // Memory, branch and jump formats; fills DEPTH=4 exactly
        start_s();
        opx(8, 5, 2, 0, 8);
        chk("t3_lw", MemWData, 32'h00812283);
        opx(9, 0, 2, 5, 12);
        chk("t3_sw", MemWData, 32'h00512623);
        opx(10, 0, 1, 2, -8);
        chk("t3_beq", MemWData, 32'hFE208CE3);
        opx(11, 0, 0, 0, 0);
        chk("t3_jal", MemWData, 32'h0000006F);
        chk("t3_jal_addr", MemAddr, BASE + 12);
        end_s();
        start_s();
        opx(13, 5, 0, 0, 32'h12345000);
        chk("t3_lui", MemWData, 32'h123452B7);
        end_s();

        // Rejections: illegal op, ADDI out of range, odd branch offset
        start_s();
        opx(14, 1, 1, 1, 0);
        opx(5, 1, 0, 0, 4096);
        opx(10, 0, 1, 2, 3);
        chk("t4_err", {31'd0, ErrIllegal}, 32'd1);
        chk("t4_count", {29'd0, Count}, 32'd0);
        opx(5, 2, 0, 0, 1);
        chk("t4_addr", MemAddr, BASE);
        chk("t4_err_sticky", {31'd0, ErrIllegal}, 32'd1);
        end_s();

        // Full: five operations offered, four written, fifth stalls
        start_s();
        for (int i = 0; i < 5; i++) opx(5, i + 1, 0, 0, i);
        chk("t5_full", {31'd0, Full}, 32'd1);
        chk("t5_inready", {31'd0, op_if.InReady}, 32'd0);
        opx(5, 7, 0, 0, 7);
        end_s();
        chk("t5_done", {31'd0, Done}, 32'd1);
        chk("t5_count", {29'd0, Count}, 32'd4);

        // Finish together with an accepted operation
        start_s();
        go(0, 1, 1, 6, 4, 3, 0, -1);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_done", {31'd0, Done}, 32'd1);

        // Start while loading is ignored, Finish in DONE is ignored
        start_s();
        go(1, 0, 1, 0, 1, 2, 3, 0);
        go(1, 0, 1, 0, 1, 2, 3, 0);
        chk("t7_count", {29'd0, Count}, 32'd2);
        end_s();
        go(0, 1, 0, 0, 0, 0, 0, 0);

        // Reset while a write is on the port
        start_s();
        opx(5, 1, 0, 0, 9);
        rst_n = 1'b0;
        op_if.InValid = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized sessions
        for (int s = 0; s < 60; s++) begin
            int ncyc;
            start_s();
            ncyc = $urandom_range(1, 8);
            for (int c = 0; c < ncyc; c++) begin
                int  op;
                bit  v;
                bit  st;
                bit  fin;
                op  = $urandom_range(0, 15);
                v   = ($urandom_range(0, 3) != 0);
                st  = ($urandom_range(0, 7) == 0);
                fin = (c == ncyc - 1);
                go(st, fin, v, op, $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), gen_imm(op));
            end
            go(0, 0, 0, 0, 0, 0, 0, 0);
            go(0, 0, $urandom_range(0, 1), 0, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder/writer side of the core's instruction decode path: accepts symbolic RV32I operations through a valid/ready handshake.
- Encodes each operation into a 32-bit machine word using the same subset the control unit decodes.
- Streams the words into instruction memory through a write port, at sequential word addresses.
- Used by bring-up benches and the boot path to build programs in place, without an external assembler.

Parameters:
- ADDR_W, 32, width of the instruction-memory write address.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written after Start.
- DEPTH, 64, maximum words per load session; Count width is $clog2(DEPTH)+1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse; begins a load session.
- Finish  in  1  one-cycle pulse; ends the session after the pipeline drains.
- InValid  in  1  operation present.
- InReady  out  1  block can accept an operation this cycle.
- Op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 ORI, 7 ANDI, 8 LW, 9 SW, 10 BEQ, 11 JAL, 12 JALR, 13 LUI; 14 and 15 are illegal.
- Rd, Rs1, Rs2  in  5 each  register fields; fields unused by Op are ignored.
- Imm  in  32  signed immediate as a full value; for LUI, the final upper-immediate value.
- MemWE  out  1  instruction-memory write strobe.
- MemAddr  out  ADDR_W  byte address of the write.
- MemWData  out  32  encoded instruction.
- Busy  out  1  session active.
- Done  out  1  level; high once the session has completed.
- Full  out  1  Count == DEPTH.
- Count  out  clog2(DEPTH)+1  number of words written this session.
- ErrIllegal  out  1  sticky; an operation was rejected.

Behaviour:
- Reset, asynchronous on rst_n low:
  - State IDLE.
  - InReady, MemWE, Busy, Done, Full and ErrIllegal are 0.
  - Count is 0, MemAddr is BASE_ADDR, MemWData is 0.
- State IDLE:
  - InReady = 0.
  - Start -> LOAD; clear Count, ErrIllegal and Done; load the address counter with BASE_ADDR.
- State LOAD:
  - Busy = 1; InReady = !Full.
  - Handshake fires when InValid && InReady.
  - Accepted operation is encoded combinationally and registered.
  - The cycle after acceptance: MemWE = 1 for exactly one cycle, MemAddr = current address, MemWData = the encoded word.
  - Then the address advances by 4 and Count increments.
  - Latency is 1 cycle; throughput is one word per cycle, with no bubble between back-to-back operations.
- Encoding rules, standard RV32I formats:
  - R-type opcode 0110011. funct3: ADD/SUB 000, AND 111, OR 110, SLT 010. funct7 is 0100000 for SUB, otherwise 0000000.
  - I-type opcode 0010011. funct3: ADDI 000, ORI 110, ANDI 111.
  - LW: opcode 0000011, funct3 010.
  - SW: opcode 0100011, funct3 010.
  - BEQ: opcode 1100011, funct3 000.
  - JAL: opcode 1101111.
  - JALR: opcode 1100111, funct3 000.
  - LUI: opcode 0110111.
- Operation rejection:
  - An operation is rejected if Op is 14 or 15, or if Imm is out of range for its format:
    - I/S formats: -2048..2047.
    - B format: -4096..4094 and even.
    - J format: -1048576..1048574 and even.
    - LUI: Imm[11:0] must be 0.
  - A rejected operation is still handshaken; no write occurs, Count and address are unchanged, and ErrIllegal sets until the next Start or reset.
- Full:
  - When Count reaches DEPTH, InReady drops in the same cycle Count updates.
  - Further operations stall; the block does not wrap to BASE_ADDR.
- Finish while in LOAD:
  - The state moves to DRAIN; InReady = 0.
  - An operation accepted in the same cycle as Finish is still written.
- State DRAIN:
  - Lasts until no write is pending (at most 1 cycle), then -> DONE.
- State DONE:
  - Done = 1, Busy = 0, InReady = 0.
  - Count and ErrIllegal hold.
  - Start -> LOAD, which begins a new session and clears Done.
- Start in LOAD or DRAIN is ignored.
- Finish in IDLE or DONE is ignored.
- Reset mid-session aborts immediately; a pending write is dropped, MemWE is never asserted during or after reset.

Test Plan:
- Start; send ADDI rd=1 rs1=0 imm=5 -> next cycle MemWE=1, MemAddr=0x0, MemWData=0x00500093; Count=1.
- Back-to-back ADD 3,1,2 then SUB 3,1,2, InValid held high -> writes 0x002081B3 @0x0 and 0x402081B3 @0x4 on consecutive cycles, no bubble.
- LW rd=5 rs1=2 imm=8, SW rs2=5 rs1=2 imm=12, BEQ rs1=1 rs2=2 imm=-8, JAL rd=0 imm=0, LUI rd=5 imm=0x12345000 -> 0x00812283, 0x00512623, 0xFE208CE3, 0x0000006F, 0x123452B7 at sequential addresses.
- Op=14; then ADDI imm=4096; then BEQ imm=3 -> three handshakes, no MemWE, ErrIllegal=1, Count unchanged; a following valid ADDI writes at the unadvanced address.
- DEPTH=4: push 5 valid operations -> 4 writes, Full=1, InReady=0, 5th stalls; Finish -> Done=1, Count=4.
- Finish in the same cycle as an accepted operation -> that word is written, then Done; rst_n low during a pending write -> no MemWE, all outputs at reset values.
